// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 receive path and its downstream
// key-tracking logic.
//   state_e          : receiver FSM states
//   FRAME_DATA_BITS  : payload bits per frame
//   FRAME_SHIFT_BITS : bits captured after the start bit (data, parity, stop)
//   BREAK_CODE       : scan-code prefix announcing a key release
//   odd_parity_ok()  : true when data plus parity bit hold an odd number of 1s
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_e;

    localparam int FRAME_DATA_BITS  = 8;
    localparam int FRAME_SHIFT_BITS = 10;
    localparam logic [FRAME_DATA_BITS-1:0] BREAK_CODE = 8'hF0;

    function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS:0] data_par);
        return ^data_par;
    endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// ----------------------------------------------------------------------------
// ps2_rx_frame_if
// Bundles the PS/2 line inputs, receive enable and the scan-code result
// signals of the frame receiver.
//   master : the receiver (samples the lines, drives the results)
//   slave  : the environment (drives the lines and rx_en, consumes results)
// ----------------------------------------------------------------------------
interface ps2_rx_frame_if;
    import ps2_pkg::*;

    logic                       ps2c;
    logic                       ps2d;
    logic                       rx_en;
    logic [FRAME_DATA_BITS-1:0] scan_code;
    logic                       scan_done_tick;
    logic                       parity_err;
    logic                       frame_err;
    logic                       busy;

    modport master (
        input  ps2c, ps2d, rx_en,
        output scan_code, scan_done_tick, parity_err, frame_err, busy
    );

    modport slave (
        output ps2c, ps2d, rx_en,
        input  scan_code, scan_done_tick, parity_err, frame_err, busy
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// ----------------------------------------------------------------------------
// ps2_clk_filter
// Brings the asynchronous PS/2 lines into the clk domain and debounces the
// PS/2 clock.
//   clk, reset : system clock, asynchronous active-high reset
//   ps2c, ps2d : raw PS/2 clock and data lines
//   fall       : one-cycle strobe on a filtered-clock 1->0 transition
//   data_sync  : synchronised data line, valid to sample while fall is high
// ----------------------------------------------------------------------------
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic fall,
    output logic data_sync
);

    logic [1:0]            c_sync_q, c_sync_d;
    logic [1:0]            d_sync_q, d_sync_d;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  level_q, level_d;

    always_comb begin
        c_sync_d = {c_sync_q[0], ps2c};
        d_sync_d = {d_sync_q[0], ps2d};
        filt_d   = {filt_q[FILTER_LEN-2:0], c_sync_q[1]};
        // Level only moves on a unanimous window; mixed windows hold it.
        level_d  = level_q;
        if (&filt_q) begin
            level_d = 1'b1;
        end else if (~|filt_q) begin
            level_d = 1'b0;
        end
    end

    // Everything resets to the idle-high line state so no edge follows reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_sync_q <= '1;
            d_sync_q <= '1;
            filt_q   <= '1;
            level_q  <= 1'b1;
        end else begin
            c_sync_q <= c_sync_d;
            d_sync_q <= d_sync_d;
            filt_q   <= filt_d;
            level_q  <= level_d;
        end
    end

    // Decoded from flops only, so the strobe is glitch-free.
    assign fall      = level_q & ~level_d;
    assign data_sync = d_sync_q[1];

endmodule

// File: rtl/ps2_rx_frame.sv
// ----------------------------------------------------------------------------
// ps2_rx_frame
// Receives PS/2 device-to-host frames (start, 8 data LSB first, odd parity,
// stop) and delivers validated scan codes with a one-cycle done pulse.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : ps2_rx_frame_if.master
//                in : ps2c, ps2d (raw lines), rx_en (frame start allowed)
//                out: scan_code, scan_done_tick, parity_err, frame_err, busy
// All outputs are registered.
// ----------------------------------------------------------------------------
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic           clk,
    input  logic           reset,
    ps2_rx_frame_if.master bus
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic fall;
    logic data_sync;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (bus.ps2c),
        .ps2d      (bus.ps2d),
        .fall      (fall),
        .data_sync (data_sync)
    );

    state_e                      state_q, state_d;
    logic [3:0]                  bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]             timeout_q, timeout_d;
    logic [FRAME_SHIFT_BITS-1:0] shreg_q, shreg_d;
    logic [FRAME_DATA_BITS-1:0]  scan_code_q, scan_code_d;
    logic                        done_q, done_d;
    logic                        perr_q, perr_d;
    logic                        ferr_q, ferr_d;
    logic                        busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        timeout_d   = timeout_q;
        shreg_d     = shreg_q;
        scan_code_d = scan_code_q;
        done_d      = 1'b0;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a low start bit with reception enabled opens a frame.
                if (fall && bus.rx_en && !data_sync) begin
                    state_d   = RECV;
                    bit_cnt_d = '0;
                    timeout_d = '0;
                end
            end
            RECV: begin
                if (fall) begin
                    // LSB first: after 10 shifts [7:0]=data, [8]=parity, [9]=stop.
                    shreg_d   = {data_sync, shreg_q[FRAME_SHIFT_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    timeout_d = '0;
                    if (bit_cnt_q == 4'(FRAME_SHIFT_BITS - 1)) begin
                        state_d = CHECK;
                    end
                end else if (timeout_q == TO_LAST) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
            CHECK: begin
                // Parity error takes precedence when stop is also bad.
                if (odd_parity_ok(shreg_q[FRAME_DATA_BITS:0]) && shreg_q[FRAME_SHIFT_BITS-1]) begin
                    scan_code_d = shreg_q[FRAME_DATA_BITS-1:0];
                    done_d      = 1'b1;
                end else if (!odd_parity_ok(shreg_q[FRAME_DATA_BITS:0])) begin
                    perr_d = 1'b1;
                end else begin
                    ferr_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            timeout_q   <= '0;
            shreg_q     <= '0;
            scan_code_q <= '0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            timeout_q   <= timeout_d;
            shreg_q     <= shreg_d;
            scan_code_q <= scan_code_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.scan_code      = scan_code_q;
    assign bus.scan_done_tick = done_q;
    assign bus.parity_err     = perr_q;
    assign bus.frame_err      = ferr_q;
    assign bus.busy           = busy_q;

endmodule
